// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_edge input-conditioning stage.
package debounce_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

  localparam logic [1:0] ENC_ST_LOW    = 2'd0;
  localparam logic [1:0] ENC_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ENC_ST_HIGH   = 2'd2;
  localparam logic [1:0] ENC_WAIT_LOW  = 2'd3;

  typedef enum logic [1:0] {
    ST_LOW    = ENC_ST_LOW,
    WAIT_HIGH = ENC_WAIT_HIGH,
    ST_HIGH   = ENC_ST_HIGH,
    WAIT_LOW  = ENC_WAIT_LOW
  } db_state_t;

endpackage

// File: rtl/sync_chain.sv
// SYNC_STAGES-deep 1-bit synchroniser; reusable by any asynchronous input stage.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronises and debounces a bouncy input into a registered level plus
// single-cycle rise/fall strobes.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       BtnIn,
  output logic       Level,
  output logic       Rise,
  output logic       Fall,
  output logic [1:0] dbg_state
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .Clk(Clk),
    .Rst(Rst),
    .d  (BtnIn),
    .q  (s)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_LOW;
      cnt   <= '0;
      Level <= 1'b0;
      Rise  <= 1'b0;
      Fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Level <= level_nxt;
      Rise  <= rise_nxt;
      Fall  <= fall_nxt;
    end
  end

  // Entering a WAIT state already counts the first differing sample, so the
  // commit lands on exactly STABLE_CYCLES consecutive samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = Level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ST_LOW: begin
        if (s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Input-conditioning stage that sits directly upstream of the team's D flip-flop stages. It takes a raw, asynchronous, bouncy input such as a push-button, synchronises it into the `Clk` domain, and debounces it. It then delivers a clean registered level suitable for driving a flip-flop `D` input, plus single-cycle rise/fall strobes for clock-enable style consumers.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth. Legal range ≥ 2.
- `STABLE_CYCLES`, default 4: consecutive synchronised samples required to accept a new level. Legal range ≥ 2.
- `Clk` input 1: single clock; all state updates on its rising edge.
- `Rst` input 1: reset, synchronous and active-high.
- `BtnIn` input 1: raw asynchronous input; may bounce arbitrarily.
- `Level` output 1: debounced, registered level. Intended to feed a downstream `D`.
- `Rise` output 1: one-cycle strobe when `Level` goes 0→1.
- `Fall` output 1: one-cycle strobe when `Level` goes 1→0.

## Operation
- Synchroniser: `SYNC_STAGES` flops in series; `s` is the last stage. Only `s` feeds the debouncer; `BtnIn` is used nowhere else.
- States: `ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`. Counter `cnt` has width `$clog2(STABLE_CYCLES)`.
- `ST_LOW`:
  - `s=1` → `WAIT_HIGH`, `cnt<=1`.
  - Otherwise hold.
- `WAIT_HIGH`:
  - `s=0` → `ST_LOW`, `cnt<=0`. This is a bounce and is rejected.
  - Else if `cnt==STABLE_CYCLES-1` → `ST_HIGH`, `Level<=1`, `Rise<=1`, `cnt<=0`.
  - Else `cnt<=cnt+1`.
- `ST_HIGH` and `WAIT_LOW`: mirror of the two states above, with `Fall` in place of `Rise`.
- Acceptance rule: a new level is accepted only after exactly `STABLE_CYCLES` consecutive equal samples of `s` that differ from `Level`. A single contrary sample restarts the count from scratch.
- `Rise`/`Fall` are registered and default to 0 every cycle. They are never both high. Each is high only in the first cycle `Level` holds its new value.
- `Level` changes only on a state commit. It never toggles twice within `STABLE_CYCLES` cycles.
- `cnt` never wraps. It is bounded by the compare, and it is reset on every state entry.

## Timing
- Reset values, applied on the first rising edge with `Rst=1`:
  - all synchroniser flops 0
  - state `ST_LOW`, `cnt=0`
  - `Level=0`, `Rise=0`, `Fall=0`
- `Rst` has priority over every other condition.
- Latency: number edge 1 as the first edge that captures a new steady `BtnIn` value. `Level` updates and the strobe asserts at edge `SYNC_STAGES+STABLE_CYCLES`. With the defaults this is edge 6.
- Reset mid-wait: any partial count is discarded. After `Rst` deasserts, the full latency applies again from the synchroniser refill.
- `BtnIn` held 1 through reset: after `Rst` falls, this is treated as a normal press. `Level` goes to 1 and `Rise` fires after `SYNC_STAGES+STABLE_CYCLES` edges.
- A bounce on the final sample before commit still rejects the change. No partial credit is kept.

## Structure
- Package `debounce_pkg` holds:
  - the state encoding (typedef `db_state_t`, 2-bit)
  - localparams for the state values
  - the default parameter values
- One sub-module: `sync_chain`, a parameterised `SYNC_STAGES`-deep 1-bit synchroniser with `Clk` and `Rst`. It is reusable by other input stages.
- The FSM, counter and strobe registers live in `debounce_edge` itself.

## Test plan
All scenarios use defaults `SYNC_STAGES=2`, `STABLE_CYCLES=4` unless stated.
1. Hold `Rst=1` for 3 cycles with `BtnIn=1`, then release → outputs are 0 during reset; `Rise=1` for exactly one cycle at the 6th edge after release; `Level=1` thereafter.
2. Clean press: `BtnIn` 0→1, held for 12 cycles → `Level=1` from edge 6; `Rise` high for exactly that one cycle; `Fall` stays 0.
3. Bounce on press: `BtnIn` = 1,1,0,1,1,1,0 then 0 for 10 cycles → `Level` stays 0; no strobes at any point.
4. Bouncy release from `Level=1`: `BtnIn` = 0,0,0,1, then 0 held → exactly one `Fall`, at edge 6 counted from the start of the steady-0 run; `Level=0` after it.
5. Reset mid-wait: `BtnIn` steady at 1; `Rst` pulsed for 1 cycle after 3 accepted samples → no `Rise` before the reset; `Rise` occurs 6 edges after `Rst` deasserts.
6. With `STABLE_CYCLES=2`: a 1-cycle high glitch → no change. A 2-cycle high run → `Rise` at edge 4, `Level=1`.
